// File: rtl/sd_param.sv
// sd_param: run-time programmable Moore sequence detector.
// Pattern, length and overlap mode are loaded through cfg_load; the serial
// stream is sampled under in_valid. A registered one-cycle det_out pulse
// follows every detection, match_cnt counts detections (saturating) and
// state_out exposes the current matched-prefix length for debug.
module sd_param #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LW-1:0]      pat_len,
    input  logic               overlap,
    input  logic               in_valid,
    input  logic               seq_in,
    output logic               det_out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [LW-1:0]      state_out
);

    // Configuration registers
    logic [MAX_LEN-1:0] r_cfg_pat;
    logic [LW-1:0]      r_cfg_len;
    logic               r_cfg_ovl;

    // Stream history: newest bit at r_hist[0]
    logic [MAX_LEN-1:0] r_hist;
    logic [LW-1:0]      r_hcnt;
    logic               r_restart;

    logic               r_det_out;
    logic [CNT_W-1:0]   r_match_cnt;

    logic [LW-1:0]      w_len_clamp;
    logic [LW-1:0]      w_hc;
    logic [MAX_LEN-1:0] w_hist_nxt;
    logic [LW-1:0]      w_hcnt_nxt;
    logic [MAX_LEN-1:0] w_len_mask;
    logic               w_match;
    logic [MAX_LEN-1:0] w_sh;
    logic [MAX_LEN-1:0] w_k_mask;
    logic               w_k_ok;
    logic [LW-1:0]      w_state;

    // Lengths beyond MAX_LEN are stored as MAX_LEN
    assign w_len_clamp = (pat_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : pat_len;

    // After a non-overlapping detection the old history no longer counts
    assign w_hc       = r_restart ? '0 : r_hcnt;
    assign w_hist_nxt = {r_hist[MAX_LEN-2:0], seq_in};
    assign w_hcnt_nxt = (w_hc == LW'(MAX_LEN)) ? w_hc : w_hc + LW'(1);

    // Match of the newest cfg_len history bits against the stored pattern
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        w_len_mask = '0;
        for (int j = 0; j < MAX_LEN; j++) begin
            w_len_mask[j] = (j < int'(r_cfg_len));
        end
        w_match = (r_cfg_len != '0) && (w_hcnt_nxt >= r_cfg_len) &&
                  (((w_hist_nxt ^ r_cfg_pat) & w_len_mask) == '0);
    end

    // Longest pattern prefix that ends the current history (debug state)
    always_comb begin
        w_state  = '0;
        w_sh     = '0;
        w_k_mask = '0;
        w_k_ok   = 1'b0;
        for (int k = 1; k <= MAX_LEN; k++) begin
            w_sh = r_cfg_pat >> (r_cfg_len - LW'(k));
            for (int j = 0; j < MAX_LEN; j++) begin
                w_k_mask[j] = (j < k);
            end
            w_k_ok = (LW'(k) <= w_hc) && (LW'(k) <= r_cfg_len) &&
                     (((r_hist ^ w_sh) & w_k_mask) == '0);
            if (w_k_ok) begin
                w_state = LW'(k);
            end
        end
        if (r_det_out) begin
            w_state = r_cfg_len;
        end
    end

    // Configuration, history, detect pulse and counter update
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            // NOTE: the history register is small and explicitly cleared; it is not a RAM, so resetting it is cheap and keeps state_out defined.
            r_cfg_pat   <= '0;
            r_cfg_len   <= '0;
            r_cfg_ovl   <= 1'b0;
            r_hist      <= '0;
            r_hcnt      <= '0;
            r_restart   <= 1'b0;
            r_det_out   <= 1'b0;
            r_match_cnt <= '0;
        end else if (cfg_load) begin
            r_cfg_pat   <= pat;
            r_cfg_len   <= w_len_clamp;
            r_cfg_ovl   <= overlap;
            r_hist      <= '0;
            r_hcnt      <= '0;
            r_restart   <= 1'b0;
            r_det_out   <= 1'b0;
            r_match_cnt <= '0;
        end else if (in_valid) begin
            r_hist    <= w_hist_nxt;
            r_hcnt    <= w_hcnt_nxt;
            r_restart <= w_match && !r_cfg_ovl;
            r_det_out <= w_match;
            if (w_match && (r_match_cnt != '1)) begin
                r_match_cnt <= r_match_cnt + CNT_W'(1);
            end
        end else begin
            r_det_out <= 1'b0;
        end
    end

    assign det_out   = r_det_out;
    assign match_cnt = r_match_cnt;
    assign state_out = (r_cfg_len == '0) ? '0 : w_state;

endmodule

// File: tb/tb_sd_param.sv
// Testbench for sd_param: directed vectors with hand-computed expectations.
// The stimulus process queues the expected outputs for each clock it drives;
// an independent monitor pops and compares one entry per cycle.
module tb_sd_param;

    localparam int MAX_LEN = 8;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] pat = '0;
    logic [LW-1:0]      pat_len = '0;
    logic               overlap = 1'b0;
    logic               in_valid = 1'b0;
    logic               seq_in = 1'b0;

    logic               det_a, det_b;
    logic [7:0]         cnt_a;
    logic [1:0]         cnt_b;
    logic [LW-1:0]      st_a, st_b;

    // Default instance and a narrow-counter instance for saturation checks
    sd_param #(.MAX_LEN(MAX_LEN), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .pat(pat), .pat_len(pat_len),
        .overlap(overlap), .in_valid(in_valid), .seq_in(seq_in),
        .det_out(det_a), .match_cnt(cnt_a), .state_out(st_a)
    );

    sd_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .pat(pat), .pat_len(pat_len),
        .overlap(overlap), .in_valid(in_valid), .seq_in(seq_in),
        .det_out(det_b), .match_cnt(cnt_b), .state_out(st_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          sel;
        logic          det;
        logic [7:0]    cnt;
        logic [LW-1:0] st;
        int            tid;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   beat     = 0;
    int   cur_tid  = 0;
    logic cur_sel  = 1'b0;

    task automatic check(input string name, input int tid, input int b,
                         input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t%0d beat %0d: got %0d expected %0d", name, tid, b, act, exp);
        end
    endtask

    // Monitor: one expected entry per cycle, sampled on the falling edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            beat++;
            if (e.sel) begin
                check("det", e.tid, beat, {7'd0, det_b}, {7'd0, e.det});
                check("cnt", e.tid, beat, {6'd0, cnt_b}, e.cnt);
                check("state", e.tid, beat, {4'd0, st_b}, {4'd0, e.st});
            end else begin
                check("det", e.tid, beat, {7'd0, det_a}, {7'd0, e.det});
                check("cnt", e.tid, beat, cnt_a, e.cnt);
                check("state", e.tid, beat, {4'd0, st_a}, {4'd0, e.st});
            end
        end
    end

    // Drive one clock worth of inputs and queue the outputs expected after it
    task automatic step(input logic r, input logic l, input logic v, input logic b,
                        input logic ed, input logic [7:0] ec, input logic [LW-1:0] es);
        exp_t e;
        @(negedge clk);
        #1;
        rst      = r;
        cfg_load = l;
        in_valid = v;
        seq_in   = b;
        e.sel = cur_sel; e.det = ed; e.cnt = ec; e.st = es; e.tid = cur_tid;
        q.push_back(e);
    endtask

    task automatic do_load(input logic [MAX_LEN-1:0] p, input logic [LW-1:0] pl,
                           input logic o, input logic v, input logic b);
        pat = p; pat_len = pl; overlap = o;
        step(1'b0, 1'b1, v, b, 1'b0, 8'd0, '0);
    endtask

    task automatic bit_in(input logic b, input logic ed, input logic [7:0] ec,
                          input logic [LW-1:0] es);
        step(1'b0, 1'b0, 1'b1, b, ed, ec, es);
    endtask

    task automatic idle(input logic b, input logic ed, input logic [7:0] ec,
                        input logic [LW-1:0] es);
        step(1'b0, 1'b0, 1'b0, b, ed, ec, es);
    endtask

    // Stream tables for the longer directed sequences
    localparam int N1 = 7;
    logic [N1-1:0] s1_bit = 7'b1101101;  // index 0 first: 1,0,1,1,0,1,1
    logic [N1-1:0] s1_det = 7'b1001000;
    int            s1_cnt[N1] = '{0, 0, 0, 1, 1, 1, 2};
    int            s1_st [N1] = '{1, 2, 3, 4, 2, 3, 4};

    localparam int N2 = 11;
    logic [N2-1:0] s2_bit = 11'b11011101101; // 1,0,1,1,0,1,1,1,0,1,1
    logic [N2-1:0] s2_det = 11'b10000001000;
    int            s2_cnt[N2] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 2};
    int            s2_st [N2] = '{1, 2, 3, 4, 0, 1, 1, 1, 2, 3, 4};

    initial begin
        // t1: reset state
        cur_tid = 1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, '0);

        // t2: 1011 overlapping
        cur_tid = 2;
        do_load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < N1; i++)
            bit_in(s1_bit[i], s1_det[i], 8'(s1_cnt[i]), LW'(s1_st[i]));

        // t3: 1011 non-overlapping, then appended 1,0,1,1
        cur_tid = 3;
        do_load(8'b0000_1011, 4'd4, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < N2; i++)
            bit_in(s2_bit[i], s2_det[i], 8'(s2_cnt[i]), LW'(s2_st[i]));

        // t4: reload 110 mid-stream; the bit offered with cfg_load is dropped
        cur_tid = 4;
        bit_in(1'b1, 1'b0, 8'd2, 4'd1);
        do_load(8'b0000_0110, 4'd3, 1'b0, 1'b1, 1'b1);
        bit_in(1'b1, 1'b0, 8'd0, 4'd1);
        bit_in(1'b1, 1'b0, 8'd0, 4'd2);
        bit_in(1'b0, 1'b1, 8'd1, 4'd3);
        bit_in(1'b1, 1'b0, 8'd1, 4'd1);
        bit_in(1'b1, 1'b0, 8'd1, 4'd2);
        bit_in(1'b0, 1'b1, 8'd2, 4'd3);

        // t5: 1011 with three idle cycles between bits, seq_in toggling
        cur_tid = 5;
        do_load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
        bit_in(1'b1, 1'b0, 8'd0, 4'd1);
        for (int i = 0; i < 3; i++) idle(1'(i), 1'b0, 8'd0, 4'd1);
        bit_in(1'b0, 1'b0, 8'd0, 4'd2);
        for (int i = 0; i < 3; i++) idle(1'(i + 1), 1'b0, 8'd0, 4'd2);
        bit_in(1'b1, 1'b0, 8'd0, 4'd3);
        for (int i = 0; i < 3; i++) idle(1'(i), 1'b0, 8'd0, 4'd3);
        bit_in(1'b1, 1'b1, 8'd1, 4'd4);
        for (int i = 0; i < 3; i++) idle(1'(i + 1), 1'b0, 8'd1, 4'd4);

        // t6: pattern length above MAX_LEN is clamped to MAX_LEN
        cur_tid = 6;
        do_load(8'b1010_1010, 4'd12, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            bit_in(1'(~i & 1), (i == 7), (i == 7) ? 8'd1 : 8'd0, LW'(i + 1));

        // t7: 2-bit counter saturation, then pattern length 0 disables
        cur_tid = 7;
        cur_sel = 1'b1;
        do_load(8'b0000_0001, 4'd1, 1'b1, 1'b0, 1'b0);
        bit_in(1'b1, 1'b1, 8'd1, 4'd1);
        bit_in(1'b1, 1'b1, 8'd2, 4'd1);
        bit_in(1'b1, 1'b1, 8'd3, 4'd1);
        bit_in(1'b1, 1'b1, 8'd3, 4'd1);
        bit_in(1'b1, 1'b1, 8'd3, 4'd1);
        idle(1'b0, 1'b0, 8'd3, 4'd1);
        do_load(8'b0000_0001, 4'd0, 1'b1, 1'b0, 1'b0);
        bit_in(1'b1, 1'b0, 8'd0, 4'd0);
        bit_in(1'b0, 1'b0, 8'd0, 4'd0);
        bit_in(1'b1, 1'b0, 8'd0, 4'd0);
        bit_in(1'b1, 1'b0, 8'd0, 4'd0);
        cur_sel = 1'b0;

        // t8: reset mid-pattern (with a competing cfg_load) clears everything
        cur_tid = 8;
        do_load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
        bit_in(1'b1, 1'b0, 8'd0, 4'd1);
        bit_in(1'b0, 1'b0, 8'd0, 4'd2);
        bit_in(1'b1, 1'b0, 8'd0, 4'd3);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, '0);
        bit_in(1'b1, 1'b0, 8'd0, 4'd0);
        do_load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
        bit_in(1'b1, 1'b0, 8'd0, 4'd1);
        bit_in(1'b1, 1'b0, 8'd0, 4'd1);
        bit_in(1'b0, 1'b0, 8'd0, 4'd2);
        bit_in(1'b1, 1'b0, 8'd0, 4'd3);
        bit_in(1'b1, 1'b1, 8'd1, 4'd4);
        idle(1'b0, 1'b0, 8'd1, 4'd4);

        // Drain the scoreboard within a fixed cycle budget
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
